// File: rtl/i2s_tx_ctrl.sv
// i2s_tx_ctrl: sample-pair FIFO and enable sequencer for an i2s_master.
// Stereo pairs arrive from the register side and are buffered in a FIFO.
// Each left-slot request from the master pops one pair into held output
// registers. The master is enabled once enough samples are buffered.
// On a stop request it is released only at a frame boundary.
// Build option: define I2S_UNDERRUN_REPEAT_EN to repeat the last popped
// pair on underrun. When it is undefined, the outputs load zero on underrun.
module i2s_tx_ctrl #(
    parameter int FIFO_DEPTH   = 8,
    parameter int START_THRESH = 2,
    parameter int LOW_THRESH   = 1,
    parameter int UCNT_W       = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ctrl_start,
    input  logic                            ctrl_stop,
    input  logic                            wr_valid,
    output logic                            wr_ready,
    input  logic [31:0]                     wr_left,
    input  logic [31:0]                     wr_right,
    input  logic                            i2s_data_rqst,
    input  logic                            i2s_ws,
    output logic                            i2s_enable,
    output logic [31:0]                     i2s_data_left,
    output logic [31:0]                     i2s_data_right,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic [UCNT_W-1:0]               underrun_cnt,
    output logic                            low_level,
    output logic                            busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [AW-1:0]     PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0]     LVL_ONE   = {{(LW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0]     LVL_ZERO  = {LW{1'b0}};
    localparam logic [LW-1:0]     LVL_FULL  = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0]     LVL_START = LW'(START_THRESH);
    localparam logic [LW-1:0]     LVL_LOW   = LW'(LOW_THRESH);
    localparam logic [UCNT_W-1:0] CNT_ONE   = {{(UCNT_W-1){1'b0}}, 1'b1};
    localparam logic [UCNT_W-1:0] CNT_MAX   = {UCNT_W{1'b1}};

    // FIFO storage (no reset needed: validity is tracked by level/pointers)
    logic [31:0] mem_left_q  [FIFO_DEPTH];
    logic [31:0] mem_right_q [FIFO_DEPTH];

    logic [1:0]        state_q, state_d;
    logic              parked_q, parked_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [UCNT_W-1:0] ucnt_q, ucnt_d;
    logic [31:0]       data_left_q, data_left_d;
    logic [31:0]       data_right_q, data_right_d;
    logic              enable_q, enable_d;
    logic              low_q, low_d;
    logic              wr_ready_q, wr_ready_d;
    logic              busy_q, busy_d;

    logic              wr_en_s;
    logic              pop_s;
    logic              underrun_s;
    logic              rqst_left_s;
    logic              empty_s;

    assign rqst_left_s = i2s_data_rqst && !i2s_ws;
    assign empty_s     = (level_q == LVL_ZERO);
    // wr_ready_q tracks the registered level, so a full FIFO refuses a write
    // even when a pop happens in the same cycle.
    assign wr_en_s     = wr_valid && wr_ready_q;

    // Sequencer: state transitions, pop/underrun decisions and parked flag
    always_comb begin
        state_d    = state_q;
        parked_d   = parked_q;
        pop_s      = 1'b0;
        underrun_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ctrl_start) begin
                    state_d = ST_PRIME;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRIME: begin
                if (ctrl_stop) begin
                    state_d = ST_IDLE;
                end else if (level_q >= LVL_START) begin
                    state_d = ST_RUN;
                    // The master consumed its left request before parking,
                    // so the pair for that slot is loaded up front.
                    if (parked_q) begin
                        pop_s    = 1'b1;
                        parked_d = 1'b0;
                    end else begin
                        pop_s    = 1'b0;
                    end
                end else begin
                    state_d = ST_PRIME;
                end
            end
            ST_RUN: begin
                if (rqst_left_s) begin
                    if (empty_s) begin
                        underrun_s = 1'b1;
                    end else begin
                        pop_s      = 1'b1;
                    end
                end else begin
                    pop_s = 1'b0;
                end
                if (ctrl_stop) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // First left-slot request is the frame boundary: park there.
                if (rqst_left_s) begin
                    parked_d = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    state_d  = ST_DRAIN;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                parked_d = 1'b0;
            end
        endcase
    end

    // FIFO pointers and occupancy
    always_comb begin
        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_en_s, pop_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // Held output pair and saturating underrun counter
    always_comb begin
        data_left_d  = data_left_q;
        data_right_d = data_right_q;
        ucnt_d       = ucnt_q;
        if (pop_s) begin
            data_left_d  = mem_left_q[rd_ptr_q];
            data_right_d = mem_right_q[rd_ptr_q];
        end else if (underrun_s) begin
`ifdef I2S_UNDERRUN_REPEAT_EN
            data_left_d  = data_left_q;
            data_right_d = data_right_q;
`else
            data_left_d  = 32'h0000_0000;
            data_right_d = 32'h0000_0000;
`endif
        end else begin
            data_left_d  = data_left_q;
            data_right_d = data_right_q;
        end
        if (underrun_s && (ucnt_q != CNT_MAX)) begin
            ucnt_d = ucnt_q + CNT_ONE;
        end else begin
            ucnt_d = ucnt_q;
        end
    end

    // Status outputs computed from next-state values so the registers line
    // up with state_q and level_q
    always_comb begin
        enable_d   = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        low_d      = (state_d == ST_RUN) && (level_d <= LVL_LOW);
        wr_ready_d = (level_d != LVL_FULL);
        busy_d     = (state_d != ST_IDLE);
    end

    // FIFO storage write port
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_left_q[wr_ptr_q]  <= wr_left;
            mem_right_q[wr_ptr_q] <= wr_right;
        end
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            parked_q     <= 1'b0;
            wr_ptr_q     <= {AW{1'b0}};
            rd_ptr_q     <= {AW{1'b0}};
            level_q      <= LVL_ZERO;
            ucnt_q       <= {UCNT_W{1'b0}};
            data_left_q  <= 32'h0000_0000;
            data_right_q <= 32'h0000_0000;
            enable_q     <= 1'b0;
            low_q        <= 1'b0;
            wr_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            parked_q     <= parked_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            ucnt_q       <= ucnt_d;
            data_left_q  <= data_left_d;
            data_right_q <= data_right_d;
            enable_q     <= enable_d;
            low_q        <= low_d;
            wr_ready_q   <= wr_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign wr_ready       = wr_ready_q;
    assign i2s_enable     = enable_q;
    assign i2s_data_left  = data_left_q;
    assign i2s_data_right = data_right_q;
    assign fifo_level     = level_q;
    assign underrun_cnt   = ucnt_q;
    assign low_level      = low_q;
    assign busy           = busy_q;

endmodule
